mux_4_1_rr_arb: RTL

MUX_4_1_RR_ARB -- requirements
Module: mux_4_1_rr_arb

---
 rtl/mux_4_1_rr_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/mux_4_1_rr_arb.sv | 92 +++++++++
 3 files changed

// File: rtl/mux_4_1_rr_pkg.sv
// Shared constants, state type and pointer helper for the 4:1 round-robin arbitrating mux.
package mux_4_1_rr_pkg;

  // Requester count is fixed at four; the select width follows from it.
  localparam int unsigned NUM_REQ       = 4;
  localparam int unsigned SEL_W         = 2;
  localparam int unsigned DEFAULT_WIDTH = 4;

  // Output slot occupancy: EMPTY means out_valid is low, FULL means it is high.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Search pointer after granting requester g: the one just after it, wrapping 3 -> 0.
  function automatic logic [SEL_W-1:0] ptr_after(input logic [SEL_W-1:0] g);
    return g + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Cyclic priority picker: grants the first set request found starting at ptr and
// walking upward modulo four. Purely combinational.
module rr_pick4
  import mux_4_1_rr_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   gnt_idx
);

  logic             found;
  logic [SEL_W-1:0] cand;

  // Walk ptr, ptr+1, ... (2-bit add wraps naturally) and take the first requester seen.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/mux_4_1_rr_arb.sv
// Four-input round-robin arbitrating mux with a single registered output slot.
// The slot accepts a new transfer whenever it is empty or being drained this cycle,
// giving one transfer per cycle under sustained load.
module mux_4_1_rr_arb
  import mux_4_1_rr_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]       in_valid,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   gnt_idx;
  logic               slot_open;
  logic               xfer;
  logic [WIDTH-1:0]   lane [NUM_REQ];

  // Split the flat input bus into per-requester lanes.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  rr_pick4 u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Slot can take a new word when empty or being drained; reset also blocks handshakes
  // since the state is EMPTY throughout reset and would otherwise look open.
  always_comb begin
    slot_open = rst_n && ((state_q == EMPTY) || out_ready);
    in_ready  = slot_open ? gnt : '0;
    xfer      = |in_ready;
  end

  // Next-state: load on a transfer, go empty on a drain with nothing to replace it,
  // otherwise hold everything (including ptr, which only moves on a transfer).
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    if (xfer) begin
      state_d    = FULL;
      ptr_d      = ptr_after(gnt_idx);
      out_data_d = lane[gnt_idx];
      out_sel_d  = gnt_idx;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State registers; reset clears the slot immediately, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      out_data_q <= '0;
      out_sel_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    out_valid = (state_q == FULL);
    out_data  = out_data_q;
    out_sel   = out_sel_q;
  end

endmodule
